// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry skid buffer with valid/ready flow control, flush and branch-taken.
// Optional performance counters (stall_cnt, flush_cnt) are built when EX_MEM_PERF_EN is defined.
module ex_mem_stage #(
    parameter int XLEN   = 64,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_pc_plus_imm,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_rd2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_zero,
    input  logic              in_branch,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pc_plus_imm,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [XLEN-1:0]   out_rd2,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_zero,
    output logic              out_branch,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              branch_taken
`ifdef EX_MEM_PERF_EN
  , output logic [31:0]       stall_cnt
  , output logic [31:0]       flush_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus_imm;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   rd2;
        logic [RD_W-1:0]   rd;
        logic              zero;
        logic              branch;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    payload_t in_payload;
    payload_t main_reg, main_next;
    payload_t skid_reg, skid_next;
    logic     main_valid_reg, main_valid_next;
    logic     skid_valid_reg, skid_valid_next;
    logic     accept;
    logic     drain;

    always_comb begin
        in_payload             = '0;
        in_payload.pc          = in_pc;
        in_payload.pc_plus_imm = in_pc_plus_imm;
        in_payload.alu_result  = in_alu_result;
        in_payload.rd2         = in_rd2;
        in_payload.rd          = in_rd;
        in_payload.zero        = in_zero;
        in_payload.branch      = in_branch;
        in_payload.ctrl        = in_ctrl;
    end

    // in_ready comes only from the skid valid register, so out_ready never reaches it combinationally.
    assign in_ready = ~skid_valid_reg;
    assign accept   = in_valid & in_ready & ~flush;
    assign drain    = main_valid_reg & out_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg || drain) begin
            if (skid_valid_reg) begin
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                main_next       = in_payload;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_next       = in_payload;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign out_valid       = main_valid_reg;
    assign out_pc          = main_reg.pc;
    assign out_pc_plus_imm = main_reg.pc_plus_imm;
    assign out_alu_result  = main_reg.alu_result;
    assign out_rd2         = main_reg.rd2;
    assign out_rd          = main_reg.rd;
    assign out_zero        = main_reg.zero;
    assign out_branch      = main_reg.branch;
    assign out_ctrl        = main_reg.ctrl;
    assign branch_taken    = main_valid_reg & main_reg.branch & main_reg.zero;

`ifdef EX_MEM_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;
    logic        stall_inc;
    logic        flush_inc;

    assign stall_inc = main_valid_reg & ~out_ready;
    assign flush_inc = flush & (main_valid_reg | skid_valid_reg);

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_inc && stall_cnt_reg != 32'hFFFF_FFFF)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (flush_inc && flush_cnt_reg != 32'hFFFF_FFFF)
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed, table-driven bench for ex_mem_stage; perf-counter sequences run when EX_MEM_PERF_EN is defined.
module tb_ex_mem_stage;

    localparam int XLEN   = 64;
    localparam int RD_W   = 5;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [XLEN-1:0]   in_pc, in_pc_plus_imm, in_alu_result, in_rd2;
    logic [RD_W-1:0]   in_rd;
    logic              in_zero, in_branch;
    logic [CTRL_W-1:0] in_ctrl;
    logic [XLEN-1:0]   out_pc, out_pc_plus_imm, out_alu_result, out_rd2;
    logic [RD_W-1:0]   out_rd;
    logic              out_zero, out_branch, branch_taken;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef EX_MEM_PERF_EN
    logic [31:0]       stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    ex_mem_stage #(.XLEN(XLEN), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc_plus_imm(in_pc_plus_imm), .in_alu_result(in_alu_result),
        .in_rd2(in_rd2), .in_rd(in_rd), .in_zero(in_zero), .in_branch(in_branch), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_plus_imm(out_pc_plus_imm), .out_alu_result(out_alu_result),
        .out_rd2(out_rd2), .out_rd(out_rd), .out_zero(out_zero), .out_branch(out_branch),
        .out_ctrl(out_ctrl), .branch_taken(branch_taken)
`ifdef EX_MEM_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct {
        logic            rst_n, flush, iv, ordy;
        logic [XLEN-1:0] pc, ppi;
        logic            z, br;
        logic            e_ov, e_ir;
        logic [XLEN-1:0] e_pc, e_ppi;
        logic            e_z, e_br, e_bt;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic r, logic f, logic iv, logic ordy, logic [XLEN-1:0] pc,
                                logic [XLEN-1:0] ppi, logic z, logic br, logic e_ov, logic e_ir,
                                logic [XLEN-1:0] e_pc, logic [XLEN-1:0] e_ppi, logic e_z,
                                logic e_br, logic e_bt);
        vec_t v;
        v.rst_n = r; v.flush = f; v.iv = iv; v.ordy = ordy;
        v.pc = pc; v.ppi = ppi; v.z = z; v.br = br;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc; v.e_ppi = e_ppi;
        v.e_z = e_z; v.e_br = e_br; v.e_bt = e_bt;
        return v;
    endfunction

    // Secondary payload fields are derived from pc so an entry's identity is checkable end to end.
    function automatic logic [XLEN-1:0] alu_of(logic [XLEN-1:0] pc); return pc << 1; endfunction
    function automatic logic [XLEN-1:0] rd2_of(logic [XLEN-1:0] pc); return pc * 5; endfunction

    task automatic drive(logic r, logic f, logic iv, logic ordy, logic [XLEN-1:0] pc,
                         logic [XLEN-1:0] ppi, logic z, logic br);
        rst_n = r; flush = f; in_valid = iv; out_ready = ordy;
        in_pc = pc; in_pc_plus_imm = ppi; in_zero = z; in_branch = br;
        in_alu_result = alu_of(pc); in_rd2 = rd2_of(pc);
        in_rd = pc[6:2]; in_ctrl = pc[5:2];
    endtask

    task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = mk(0,0,1,1,64'h1000,64'h0,  0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[1]  = mk(0,0,1,1,64'h1000,64'h0,  0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[2]  = mk(1,0,1,1,64'h0,  64'h100,0,0, 1,1,64'h0, 64'h100,0,0,0);
        vecs[3]  = mk(1,0,1,1,64'h4,  64'h104,0,0, 1,1,64'h4, 64'h104,0,0,0);
        vecs[4]  = mk(1,0,1,1,64'h8,  64'h108,0,0, 1,1,64'h8, 64'h108,0,0,0);
        vecs[5]  = mk(1,0,1,1,64'hC,  64'h10C,0,0, 1,1,64'hC, 64'h10C,0,0,0);
        vecs[6]  = mk(1,0,0,1,64'h0,  64'h0,  0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[7]  = mk(1,0,1,0,64'h10, 64'h110,0,0, 1,1,64'h10,64'h110,0,0,0);
        vecs[8]  = mk(1,0,1,0,64'h14, 64'h114,0,0, 1,0,64'h10,64'h110,0,0,0);
        vecs[9]  = mk(1,0,1,0,64'h18, 64'h118,0,0, 1,0,64'h10,64'h110,0,0,0);
        vecs[10] = mk(1,0,1,1,64'h18, 64'h118,0,0, 1,1,64'h14,64'h114,0,0,0);
        vecs[11] = mk(1,0,1,1,64'h18, 64'h118,0,0, 1,1,64'h18,64'h118,0,0,0);
        vecs[12] = mk(1,0,0,1,64'h0,  64'h0,  0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[13] = mk(1,0,1,0,64'h20, 64'h120,0,0, 1,1,64'h20,64'h120,0,0,0);
        vecs[14] = mk(1,0,1,0,64'h24, 64'h124,0,0, 1,0,64'h20,64'h120,0,0,0);
        vecs[15] = mk(1,1,1,0,64'h28, 64'h128,0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[16] = mk(1,0,0,1,64'h0,  64'h0,  0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[17] = mk(1,0,1,0,64'h40, 64'h400,1,1, 1,1,64'h40,64'h400,1,1,1);
        vecs[18] = mk(1,0,0,0,64'h0,  64'h0,  0,0, 1,1,64'h40,64'h400,1,1,1);
        vecs[19] = mk(1,0,0,1,64'h0,  64'h0,  0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[20] = mk(1,0,1,1,64'h44, 64'h400,0,1, 1,1,64'h44,64'h400,0,1,0);
        vecs[21] = mk(1,0,0,1,64'h0,  64'h0,  0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[22] = mk(1,0,1,0,64'h48, 64'h800,1,1, 1,1,64'h48,64'h800,1,1,1);
        vecs[23] = mk(1,1,0,0,64'h0,  64'h0,  0,0, 0,1,64'h0, 64'h0,  0,0,0);
        vecs[24] = mk(1,0,1,0,64'h50, 64'h150,0,0, 1,1,64'h50,64'h150,0,0,0);
        vecs[25] = mk(0,1,1,0,64'h54, 64'h154,0,0, 0,1,64'h0, 64'h0,  0,0,0);

        drive(0,0,0,1,64'h0,64'h0,0,0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].iv, vecs[i].ordy,
                  vecs[i].pc, vecs[i].ppi, vecs[i].z, vecs[i].br);
            @(posedge clk); #1;
            n_vec++;
            chk("out_valid", {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            chk("in_ready", {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
            chk("branch_taken", {63'd0, branch_taken}, {63'd0, vecs[i].e_bt});
            if (vecs[i].e_ov || !vecs[i].rst_n) begin
                chk("out_pc", out_pc, vecs[i].e_pc);
                chk("out_pc_plus_imm", out_pc_plus_imm, vecs[i].e_ppi);
                chk("out_alu_result", out_alu_result, alu_of(vecs[i].e_pc));
                chk("out_rd2", out_rd2, rd2_of(vecs[i].e_pc));
                chk("out_rd", {59'd0, out_rd}, {59'd0, vecs[i].e_pc[6:2]});
                chk("out_ctrl", {60'd0, out_ctrl}, {60'd0, vecs[i].e_pc[5:2]});
                chk("out_zero", {63'd0, out_zero}, {63'd0, vecs[i].e_z});
                chk("out_branch", {63'd0, out_branch}, {63'd0, vecs[i].e_br});
            end
            $display("vec %0d: rst_n=%0b flush=%0b in_valid=%0b out_ready=%0b in_pc=0x%0h -> out_valid=%0b out_pc=0x%0h in_ready=%0b branch_taken=%0b",
                     i, vecs[i].rst_n, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].pc,
                     out_valid, out_pc, in_ready, branch_taken);
        end

`ifdef EX_MEM_PERF_EN
        // Three stall cycles then a flush with main valid (out_ready high so the flush cycle is not a stall).
        drive(0,0,0,1,64'h0,64'h0,0,0);
        @(posedge clk); #1;
        n_vec++;
        chk("stall_cnt_reset", {32'd0, stall_cnt}, 64'd0);
        chk("flush_cnt_reset", {32'd0, flush_cnt}, 64'd0);
        drive(1,0,1,0,64'h60,64'h0,0,0);
        @(posedge clk); #1;
        drive(1,0,0,0,64'h0,64'h0,0,0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        drive(1,1,0,1,64'h0,64'h0,0,0);
        @(posedge clk); #1;
        n_vec++;
        chk("stall_cnt_3", {32'd0, stall_cnt}, 64'd3);
        chk("flush_cnt_1", {32'd0, flush_cnt}, 64'd1);
        $display("perf: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);

        // Saturation: preload near the top, then stall three more cycles.
        drive(1,0,1,0,64'h64,64'h0,0,0);
        @(posedge clk); #1;
        drive(1,0,0,0,64'h0,64'h0,0,0);
        @(negedge clk);
        force dut.stall_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_reg;
        @(posedge clk); #1;
        n_vec++;
        chk("stall_cnt_top", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_vec++;
        chk("stall_cnt_sat", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
        $display("perf: saturated stall_cnt=0x%0h", stall_cnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline stage for the 64-bit RISC-V datapath. It replaces the bare always-latching EX/MEM register with a two-entry skid buffer that adds:
- valid/ready flow control, so a slow data memory can back-pressure execute;
- synchronous flush, for branch/exception squash;
- carried control fields and a registered branch-taken indication for fetch.

It sits between the execute stage (ALU, branch adder) and the memory stage.

## Interface
Parameters:
- XLEN, 64, width of pc, pc_plus_imm, alu_result, rd2 datapaths
- RD_W, 5, destination-register index width
- CTRL_W, 4, width of opaque control bundle (reg_write, mem_read, mem_write, mem_to_reg by convention; not interpreted here)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  squash everything held and drop this cycle's input
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; equals NOT skid_valid
- in_pc  in  XLEN  instruction PC
- in_pc_plus_imm  in  XLEN  branch target
- in_alu_result  in  XLEN  ALU result / memory address
- in_rd2  in  XLEN  store data
- in_rd  in  RD_W  destination register index
- in_zero  in  1  ALU zero flag
- in_branch  in  1  instruction is a conditional branch
- in_ctrl  in  CTRL_W  control bundle
- out_valid  out  1  main entry holds a live instruction
- out_ready  in  1  memory stage consumes the entry this cycle
- out_pc, out_pc_plus_imm, out_alu_result, out_rd2  out  XLEN  registered copies
- out_rd  out  RD_W; out_zero, out_branch  out  1; out_ctrl  out  CTRL_W
- branch_taken  out  1  out_valid AND out_branch AND out_zero (combinational from registers)

## Operation
- Two entries: main (drives out_*) and skid. Each entry has a valid bit and a full payload copy.
- accept = in_valid & in_ready & ~flush.
- drain = out_valid & out_ready.
- Priority each cycle: reset, then flush, then normal.
- Reset (rst_n=0 at posedge):
  - both valid bits clear;
  - every payload register, including out_* fields, cleared to 0;
  - in_ready reads 1.
- Flush:
  - both valid bits clear; input not captured; payload registers keep their contents (don't-care);
  - branch_taken is 0 the following cycle.
  - Flush with rst_n=0: reset wins (identical except payload zeroed).
- Normal operation, main empty or draining:
  - skid valid: skid moves to main, skid clears; an accept in the same cycle is impossible (in_ready=0).
  - skid empty and accept: input loads main.
  - otherwise: main valid clears if it drained.
- Normal operation, main valid and not draining:
  - accept: input loads skid, skid valid sets; main unchanged.
- out_* are stable while out_valid=1 and out_ready=0. No entry is ever overwritten while valid.
- Order is preserved: main is always older than skid.

## Timing
- Latency: input accepted at edge N appears on out_* after edge N, visible in cycle N+1, when the stage is empty.
- Throughput: 1 instruction/cycle with out_ready held high. in_ready stays 1 in that case.
- One stall cycle (out_ready=0) with in_valid=1: the second instruction goes to skid and in_ready drops to 0 in the next cycle.
- in_ready returns to 1 one cycle after the skid entry moves to main.
- in_ready depends only on registers; there is no combinational path from out_ready to in_ready.
- branch_taken is combinational from main-entry registers only.

## Configuration
- EX_MEM_PERF_EN defined adds:
  - output stall_cnt [31:0]: increments each cycle out_valid & ~out_ready;
  - output flush_cnt [31:0]: increments each flush cycle in which either entry was valid;
  - both counters saturate at 0xFFFF_FFFF and reset to 0;
  - a flush cycle with out_valid=1 and out_ready=0 increments both counters.
- EX_MEM_PERF_EN undefined: counters and ports absent. Datapath behaviour is identical.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 and in_pc=0x1000 -> out_valid=0, all out_* =0, in_ready=1, branch_taken=0.
- Streaming: out_ready=1, send pc 0x0,0x4,0x8,0xC on consecutive cycles -> each appears one cycle later in order; in_ready stays 1.
- Back-pressure: out_ready=0 while sending pc 0x10,0x14,0x18 -> out_pc holds 0x10, skid takes 0x14, in_ready=0, 0x18 held upstream; release out_ready -> outputs 0x10,0x14,0x18 in order, none lost or duplicated.
- Flush: main=0x20, skid=0x24, assert flush with in_valid=1 and in_pc=0x28 -> next cycle out_valid=0, in_ready=1, 0x28 never appears.
- Branch: accept in_branch=1, in_zero=1, in_pc_plus_imm=0x400 -> branch_taken=1 and out_pc_plus_imm=0x400 for exactly the cycles out_valid=1; with in_zero=0 -> branch_taken stays 0.
- EX_MEM_PERF_EN: 3 stalled cycles, then 1 flush with main valid -> stall_cnt=3, flush_cnt=1; force stall_cnt to 0xFFFF_FFFE and apply 3 stall cycles -> stall_cnt=0xFFFF_FFFF.
